// File: rtl/ise_ratio_cmp_arbiter.sv
// -----------------------------------------------------------------------------
// ise_ratio_cmp_arbiter
//
// Purpose:
//   Shares one serial ratio comparator among N_REQ requesters of the image
//   sorting engine. Each request presents two (cnt, mag) pairs. The block
//   answers whether the average intensity mag_a/cnt_a is greater than or equal
//   to mag_b/cnt_b. It does this by cross multiplication: two shift-add
//   multipliers form P1 = mag_a*cnt_b and P2 = mag_b*cnt_a, and the products
//   are then compared. A round-robin arbiter decides which requester is served.
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous, active-high reset
//   req       in   [N_REQ]        per-requester request level
//   cnt_a_in  in   [N_REQ*CNT_W]  cnt_a of requester k at [k*CNT_W +: CNT_W]
//   mag_a_in  in   [N_REQ*MAG_W]  mag_a of requester k at [k*MAG_W +: MAG_W]
//   cnt_b_in  in   [N_REQ*CNT_W]  cnt_b, packed like cnt_a_in
//   mag_b_in  in   [N_REQ*MAG_W]  mag_b, packed like mag_a_in
//   gnt       out  [N_REQ]        one-hot, one-cycle pulse: operands captured
//   busy      out                 a compare is in flight
//   done      out                 one-cycle result-valid pulse
//   done_id   out  [ID_W]         requester that owns the result
//   gt        out                 P1 >  P2, held until the next done
//   eq        out                 P1 == P2, held until the next done
//
// Timing:
//   The result appears MAG_W+1 cycles after the capture edge. Back-to-back
//   compares are spaced MAG_W+2 cycles apart.
//
// Optional build macro:
//   ISE_EARLY_EXIT_EN - an identical pair (mag_a==mag_b and cnt_a==cnt_b)
//   skips the multiply phase. Its result (eq=1, gt=0) appears one cycle after
//   capture. Leave the macro undefined to give every compare the full latency.
// -----------------------------------------------------------------------------
module ise_ratio_cmp_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 15,
  parameter int MAG_W = 22,
  parameter int ID_W  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*CNT_W-1:0]   cnt_a_in,
  input  logic [N_REQ*MAG_W-1:0]   mag_a_in,
  input  logic [N_REQ*CNT_W-1:0]   cnt_b_in,
  input  logic [N_REQ*MAG_W-1:0]   mag_b_in,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic                     done,
  output logic [ID_W-1:0]          done_id,
  output logic                     gt,
  output logic                     eq
);

  // The product register holds the partial product in its upper CNT_W bits
  // and the not-yet-consumed multiplier bits in its lower MAG_W bits.
  localparam int PROD_W = CNT_W + MAG_W;
  localparam int IT_W   = (MAG_W > 1) ? $clog2(MAG_W) : 1;

  localparam logic [IT_W-1:0] IT_LAST   = IT_W'(MAG_W - 1);
  localparam logic [IT_W-1:0] IT_ONE    = {{(IT_W-1){1'b0}}, 1'b1};
  localparam logic [ID_W-1:0] PTR_RESET = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_CMP  = 2'd2
  } state_t;

  state_t                 state_r;
  logic [ID_W-1:0]        ptr_r;
  logic [IT_W-1:0]        it_cnt_r;
  logic [PROD_W-1:0]      p1_r;
  logic [PROD_W-1:0]      p2_r;
  logic [CNT_W-1:0]       mcand1_r;   // cnt_b, multiplicand of P1
  logic [CNT_W-1:0]       mcand2_r;   // cnt_a, multiplicand of P2
  logic [N_REQ-1:0]       gnt_r;
  logic                   busy_r;
  logic                   done_r;
  logic [ID_W-1:0]        done_id_r;
  logic                   gt_r;
  logic                   eq_r;
`ifdef ISE_EARLY_EXIT_EN
  logic                   early_r;
`endif

  logic                   win_valid_s;
  logic [ID_W-1:0]        win_idx_s;
  logic [N_REQ-1:0]       win_gnt_s;
  logic [CNT_W-1:0]       sel_cnt_a_s;
  logic [MAG_W-1:0]       sel_mag_a_s;
  logic [CNT_W-1:0]       sel_cnt_b_s;
  logic [MAG_W-1:0]       sel_mag_b_s;
  logic [PROD_W-1:0]      p1_next_s;
  logic [PROD_W-1:0]      p2_next_s;

  // One shift-add step. When the next multiplier bit (LSB) is set, the
  // multiplicand is added into the upper field. The CNT_W+1-bit sum keeps the
  // carry, and that carry drops back into the top bit on the right shift.
  function automatic logic [PROD_W-1:0] mul_step(
    input logic [PROD_W-1:0] prod,
    input logic [CNT_W-1:0]  mcand
  );
    logic [CNT_W:0] sum;
    if (prod[0]) begin
      sum = {1'b0, prod[PROD_W-1:MAG_W]} + {1'b0, mcand};
    end else begin
      sum = {1'b0, prod[PROD_W-1:MAG_W]};
    end
    return {sum, prod[MAG_W-1:1]};
  endfunction

  // Round-robin winner search and operand selection. Each requester is ranked
  // by its distance past the pointer, so ptr+1 has the highest priority. Only
  // constant indices are used, so the selection unrolls into plain muxes.
  always_comb begin : win_search
    int best_d;
    int d;
    win_valid_s = 1'b0;
    win_idx_s   = '0;
    win_gnt_s   = '0;
    sel_cnt_a_s = '0;
    sel_mag_a_s = '0;
    sel_cnt_b_s = '0;
    sel_mag_b_s = '0;
    best_d      = N_REQ;
    d           = 32'sd0;
    for (int k = 0; k < N_REQ; k++) begin
      d = k - int'(ptr_r) - 32'sd1;
      d = (d < 32'sd0) ? (d + N_REQ) : d;
      if (req[k] && (d < best_d)) begin
        best_d       = d;
        win_valid_s  = 1'b1;
        win_idx_s    = ID_W'(k);
        win_gnt_s    = '0;
        win_gnt_s[k] = 1'b1;
        sel_cnt_a_s  = cnt_a_in[k*CNT_W +: CNT_W];
        sel_mag_a_s  = mag_a_in[k*MAG_W +: MAG_W];
        sel_cnt_b_s  = cnt_b_in[k*CNT_W +: CNT_W];
        sel_mag_b_s  = mag_b_in[k*MAG_W +: MAG_W];
      end else begin
        best_d = best_d;
      end
    end
  end

  // Next value of both multipliers; the two run in lockstep.
  assign p1_next_s = mul_step(p1_r, mcand1_r);
  assign p2_next_s = mul_step(p2_r, mcand2_r);

  // Control FSM, multiplier datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      ptr_r     <= PTR_RESET;
      it_cnt_r  <= '0;
      p1_r      <= '0;
      p2_r      <= '0;
      mcand1_r  <= '0;
      mcand2_r  <= '0;
      gnt_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      done_id_r <= '0;
      gt_r      <= 1'b0;
      eq_r      <= 1'b0;
`ifdef ISE_EARLY_EXIT_EN
      early_r   <= 1'b0;
`endif
    end else begin
      // gnt and done are single-cycle pulses.
      gnt_r  <= '0;
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (win_valid_s) begin
            ptr_r    <= win_idx_s;
            gnt_r    <= win_gnt_s;
            it_cnt_r <= '0;
            busy_r   <= 1'b1;
            // Each magnitude is loaded as the multiplier in the low bits and is
            // consumed one bit per cycle. The count acts as the multiplicand.
            p1_r     <= {{CNT_W{1'b0}}, sel_mag_a_s};
            mcand1_r <= sel_cnt_b_s;
            p2_r     <= {{CNT_W{1'b0}}, sel_mag_b_s};
            mcand2_r <= sel_cnt_a_s;
`ifdef ISE_EARLY_EXIT_EN
            if ((sel_mag_a_s == sel_mag_b_s) && (sel_cnt_a_s == sel_cnt_b_s)) begin
              early_r <= 1'b1;
              state_r <= ST_CMP;
            end else begin
              early_r <= 1'b0;
              state_r <= ST_MUL;
            end
`else
            state_r  <= ST_MUL;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_MUL: begin
          p1_r <= p1_next_s;
          p2_r <= p2_next_s;
          if (it_cnt_r == IT_LAST) begin
            state_r <= ST_CMP;
          end else begin
            it_cnt_r <= it_cnt_r + IT_ONE;
          end
        end

        ST_CMP: begin
`ifdef ISE_EARLY_EXIT_EN
          gt_r <= early_r ? 1'b0 : (p1_r > p2_r);
          eq_r <= early_r ? 1'b1 : (p1_r == p2_r);
`else
          gt_r <= (p1_r > p2_r);
          eq_r <= (p1_r == p2_r);
`endif
          done_r    <= 1'b1;
          done_id_r <= ptr_r;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end

        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt     = gnt_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign done_id = done_id_r;
  assign gt      = gt_r;
  assign eq      = eq_r;

endmodule

// File: doc/ise_ratio_cmp_arbiter.md
Name: ise_ratio_cmp_arbiter

Overview:
- Shares one serial ratio comparator among N_REQ requesters in the image sorting engine, e.g. parallel sort lanes or a merge stage.
- Each request carries two (cnt, mag) pairs. The block answers whether average intensity A (mag_a/cnt_a) is greater than or equal to B (mag_b/cnt_b).
- The answer comes from cross multiplication using two shift-add multipliers, with no divider.
- A round-robin arbiter sequences access and returns a tagged result.

Parameters:
- N_REQ, 4, number of requesters, 2..8.
- CNT_W, 15, width of the pixel-count operands.
- MAG_W, 22, width of the magnitude-sum operands; also the multiply iteration count.
- ID_W, 2, width of done_id; must be at least log2(N_REQ).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req  in  N_REQ  per-requester request level.
- cnt_a_in  in  N_REQ*CNT_W  cnt_a of requester k in bits [k*CNT_W +: CNT_W].
- mag_a_in  in  N_REQ*MAG_W  mag_a, packed the same way.
- cnt_b_in  in  N_REQ*CNT_W  cnt_b, packed the same way.
- mag_b_in  in  N_REQ*MAG_W  mag_b, packed the same way.
- gnt  out  N_REQ  one-hot registered pulse; operands were captured.
- busy  out  1  high while a compare is in flight (state not IDLE).
- done  out  1  one-cycle result-valid pulse.
- done_id  out  ID_W  index of the requester owning the result.
- gt  out  1  mag_a*cnt_b > mag_b*cnt_a; valid when done is high.
- eq  out  1  mag_a*cnt_b == mag_b*cnt_a; valid when done is high.

Behaviour:
- Reset: already decided as reset, synchronous, active-high; clock clk.
  - At reset: state=IDLE; gnt=0, busy=0, done=0, done_id=0, gt=0, eq=0; round-robin pointer ptr=N_REQ-1, so requester 0 wins first.
  - Reset asserted mid-compare aborts it. No done is issued and no gnt is reissued.
- States: IDLE, MUL, CMP.
- IDLE:
  - If req is nonzero, the winner is the first set bit searching ptr+1, ptr+2, ... with wraparound.
  - On that edge: capture the winner's operands; set ptr=winner; set gnt[winner]=1 for exactly one cycle; clear the iteration counter; go to MUL.
  - With req=0, stay in IDLE.
- Requester rules:
  - Hold req and operands stable until gnt is seen.
  - Deassert req in the gnt cycle, unless it wants another compare. A req still high after gnt is a new request.
- MUL:
  - Two parallel shift-add multipliers run: P1 = mag_a * cnt_b and P2 = mag_b * cnt_a.
  - Each product register is CNT_W+MAG_W bits wide. It is initialised with the magnitude in its low bits.
  - Each cycle: if the LSB is 1, add the multiplicand to the upper CNT_W bits into a CNT_W+1-bit sum; then shift right by one.
  - Exactly MAG_W iterations; the counter runs 0..MAG_W-1, then go to CMP.
- CMP:
  - Register gt=(P1>P2), eq=(P1==P2), done_id=ptr, done=1; go to IDLE.
  - done is high in the first IDLE cycle, and arbitration may occur in that same cycle.
- Timing:
  - Latency from the capture edge to done high is MAG_W+1 cycles.
  - Back-to-back spacing is MAG_W+2 cycles.
- Arithmetic: all unsigned.
  - cnt=0 is legal; both counts 0 gives eq=1, gt=0.
  - No overflow is possible, since the product width is CNT_W+MAG_W.
- gt and eq hold their values until the next done.
- gnt and done never assert in the same cycle for the same transaction.

Optional Feature:
- ISE_EARLY_EXIT_EN defined:
  - In IDLE, at capture, if the winner's mag_a==mag_b and cnt_a==cnt_b, skip MUL and go straight to CMP with forced eq=1, gt=0.
  - done then comes 1 cycle after the capture edge.
- Undefined: every compare takes the full MAG_W+1 latency.

Test Plan:
- Requester 0 only, mag_a=300, cnt_a=3, mag_b=198, cnt_b=2 (600 vs 594):
  - gnt=4'b0001 one cycle after the capture edge.
  - done 23 cycles after capture, done_id=0, gt=1, eq=0.
- Requester 2, mag_a=100, cnt_a=4, mag_b=50, cnt_b=2 (200 vs 200) -> done_id=2, gt=0, eq=1.
- req=4'b1111 held continuously, distinct operands -> grant order 0,1,2,3,0; done_id follows the same order; grants spaced 24 cycles apart.
- Extremes: mag_a=22'h3FFFFF, cnt_a=15'h7FFF, mag_b=22'h3FFFFE, cnt_b=15'h7FFF -> gt=1. Swapping A and B -> gt=0, eq=0.
- Reset pulsed 10 cycles into MUL -> no done; busy=0 next cycle; the next grant goes to requester 0.
- ISE_EARLY_EXIT_EN, identical pairs (mag=500, cnt=5) -> done 1 cycle after capture, eq=1. Without the macro -> done after 23 cycles, eq=1.
